// File: rtl/lcd_hex_stream_if.sv
// lcd_hex_stream_if: start/data input and LCD transaction-layer handshakes for lcd_hex_stream
interface lcd_hex_stream_if #(parameter int NUM_BYTES = 3);
  logic start;
  logic data_valid;
  logic [8*NUM_BYTES-1:0] data_in;
  logic do_return_cursor_home;
  logic return_cursor_home_done;
  logic do_write_cmd;
  logic [7:0] cmd_to_write;
  logic send_cmd_done;
  logic do_write_data;
  logic [7:0] data_to_write;
  logic send_data_done;
  logic busy;
  logic done;
  modport master (
    input start, data_valid, data_in, return_cursor_home_done, send_cmd_done, send_data_done,
    output do_return_cursor_home, do_write_cmd, cmd_to_write, do_write_data, data_to_write, busy, done
  );
  modport slave (
    output start, data_valid, data_in, return_cursor_home_done, send_cmd_done, send_data_done,
    input do_return_cursor_home, do_write_cmd, cmd_to_write, do_write_data, data_to_write, busy, done
  );
endinterface

// File: rtl/lcd_hex_stream.sv
// lcd_hex_stream: homes the LCD, snapshots NUM_BYTES bytes and streams them as hex ASCII characters
module lcd_hex_stream #(
  parameter int NUM_BYTES = 3,
  parameter int LINE_CHARS = 16,
  parameter int TWO_LINE = 1,
  parameter int SPACED = 1,
  parameter int UPPERCASE = 1,
  parameter logic [7:0] LINE2_ADDR = 8'hC0
) (
  input logic clk,
  input logic reset,
  lcd_hex_stream_if.master bus
);
  localparam logic [3:0] IDLE = 4'd0, HOME = 4'd1, WAIT_DATA = 4'd2, LOAD = 4'd3, SEND = 4'd4,
                         GAP = 4'd5, LINE2 = 4'd6, GAP2 = 4'd7, FINISH = 4'd8;
  localparam int TOTAL = NUM_BYTES * (2 + SPACED) - SPACED;
  localparam int LIMIT = LINE_CHARS * (1 + TWO_LINE);
  localparam logic [7:0] NCH = 8'(TOTAL < LIMIT ? TOTAL : LIMIT);
  localparam logic [7:0] LC = 8'(LINE_CHARS);
  localparam logic [7:0] STRIDE = 8'(2 + SPACED);
  logic [3:0] state_q, state_d;
  logic home_q, home_d, cmd_q, cmd_d, wr_q, wr_d, done_q, done_d, pend_q, pend_d;
  logic [7:0] data_q, data_d, cmdb_q, cmdb_d, idx_q, idx_d;
  logic [8*NUM_BYTES-1:0] snap_q, snap_d, sh;
  logic [7:0] b, p, chr;
  logic [3:0] nib;
  logic restart;
  always_comb begin
    b = idx_q / STRIDE;
    p = idx_q % STRIDE;
    sh = snap_q << {b, 3'b000};
    nib = (p == 8'd0) ? sh[8*NUM_BYTES-1 -: 4] : sh[8*NUM_BYTES-5 -: 4];
    chr = (p == 8'd2) ? 8'h20 :
          (nib < 4'd10) ? 8'h30 + {4'h0, nib} : (UPPERCASE != 0 ? 8'h37 : 8'h57) + {4'h0, nib};
  end
  // a pending start is only honoured once the in-flight handshake has closed
  assign restart = (bus.start && (state_q == IDLE || state_q == WAIT_DATA || state_q == LOAD ||
                                  state_q == GAP || state_q == GAP2)) ||
                   (pend_q && (state_q == GAP || state_q == GAP2));
  always_comb begin
    state_d = state_q;
    home_d = home_q;
    cmd_d = cmd_q;
    wr_d = wr_q;
    done_d = 1'b0;
    pend_d = pend_q;
    data_d = data_q;
    cmdb_d = cmdb_q;
    idx_d = idx_q;
    snap_d = snap_q;
    case (state_q)
      HOME: if (bus.return_cursor_home_done) begin
        home_d = 1'b0;
        state_d = WAIT_DATA;
      end
      WAIT_DATA: if (bus.data_valid) begin
        snap_d = bus.data_in;
        idx_d = 8'd0;
        state_d = LOAD;
      end
      LOAD: begin
        data_d = chr;
        wr_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        pend_d = pend_q | bus.start;
        if (bus.send_data_done) begin
          wr_d = 1'b0;
          idx_d = idx_q + 8'd1;
          state_d = GAP;
        end
      end
      GAP: if (idx_q == NCH) begin
        done_d = 1'b1;
        state_d = FINISH;
      end else if (TWO_LINE != 0 && idx_q == LC) begin
        cmdb_d = LINE2_ADDR;
        cmd_d = 1'b1;
        state_d = LINE2;
      end else state_d = LOAD;
      LINE2: begin
        pend_d = pend_q | bus.start;
        if (bus.send_cmd_done) begin
          cmd_d = 1'b0;
          state_d = GAP2;
        end
      end
      GAP2: state_d = LOAD;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = HOME;
      home_d = 1'b1;
      cmd_d = 1'b0;
      wr_d = 1'b0;
      done_d = 1'b0;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      home_q <= 1'b0;
      cmd_q <= 1'b0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
      pend_q <= 1'b0;
      data_q <= 8'h00;
      cmdb_q <= 8'h00;
      idx_q <= 8'd0;
      snap_q <= '0;
    end else begin
      state_q <= state_d;
      home_q <= home_d;
      cmd_q <= cmd_d;
      wr_q <= wr_d;
      done_q <= done_d;
      pend_q <= pend_d;
      data_q <= data_d;
      cmdb_q <= cmdb_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
    end
  end
  assign bus.do_return_cursor_home = home_q;
  assign bus.do_write_cmd = cmd_q;
  assign bus.cmd_to_write = cmdb_q;
  assign bus.do_write_data = wr_q;
  assign bus.data_to_write = data_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
endmodule

// File: tb/tb_lcd_hex_stream.sv
// tb_lcd_hex_stream: four parameterisations driven by directed steps; an auto-acking transaction layer logs traffic
module tb_lcd_hex_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] start = '0, dv = '0, hd = '0, cd = '0, sda = '0, sdm = '0, ack_en = '1;
  logic [3:0] sd, dh, dc, dw, bsy, dn;
  logic [63:0] din [4];
  logic [7:0] cw [4], dtw [4], lastcmd [4];
  logic [7:0] ch [4][64];
  int hc [4], cc [4], sc [4], n [4], ncmd [4], cmd_at [4], ndone [4], viol [4];
  int total = 0, bad = 0;
  assign sd = sda | sdm;
  // instances: 0 = 3B upper, 1 = 3B lower, 2 = 8B two-line, 3 = 8B one-line
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int NB = g < 2 ? 3 : 8;
    lcd_hex_stream_if #(.NUM_BYTES(NB)) bus ();
    assign bus.start = start[g];
    assign bus.data_valid = dv[g];
    assign bus.data_in = din[g][8*NB-1:0];
    assign bus.return_cursor_home_done = hd[g];
    assign bus.send_cmd_done = cd[g];
    assign bus.send_data_done = sd[g];
    assign dh[g] = bus.do_return_cursor_home;
    assign dc[g] = bus.do_write_cmd;
    assign dw[g] = bus.do_write_data;
    assign bsy[g] = bus.busy;
    assign dn[g] = bus.done;
    assign cw[g] = bus.cmd_to_write;
    assign dtw[g] = bus.data_to_write;
    lcd_hex_stream #(.NUM_BYTES(NB), .TWO_LINE(g == 3 ? 0 : 1), .UPPERCASE(g == 1 ? 0 : 1)) dut (
      .clk(clk), .reset(rst), .bus(bus));
  end
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      hc[k] <= (dh[k] && !hd[k]) ? hc[k] + 1 : 0;
      hd[k] <= dh[k] && !hd[k] && hc[k] == 2;
      cc[k] <= (dc[k] && !cd[k]) ? cc[k] + 1 : 0;
      cd[k] <= dc[k] && !cd[k] && cc[k] == 1;
      sc[k] <= (dw[k] && !sda[k]) ? sc[k] + 1 : 0;
      sda[k] <= ack_en[k] && dw[k] && !sda[k] && sc[k] == 1;
      if (dw[k] && sd[k]) begin
        ch[k][n[k]] <= dtw[k];
        n[k] <= n[k] + 1;
      end
      if (dc[k] && cd[k]) begin
        ncmd[k] <= ncmd[k] + 1;
        lastcmd[k] <= cw[k];
        cmd_at[k] <= n[k];
      end
      if (dn[k]) ndone[k] <= ndone[k] + 1;
      if (32'(dh[k]) + 32'(dc[k]) + 32'(dw[k]) > 1) viol[k] <= viol[k] + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic chk_str(input string tag, input int k, input int base, input int cnt, input logic [255:0] exp);
    for (int j = 0; j < cnt; j++)
      chk($sformatf("%s[%0d]", tag, j), 32'(ch[k][base+j]), 32'(exp[8*(cnt-1-j) +: 8]));
  endtask
  task automatic pulse(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask
  task automatic wait_done(input int k, input string tag);
    int c = 0;
    while (!dn[k] && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(dn[k]), 32'd1);
  endtask
  initial begin
    int b0, d0, c0, c;
    for (int k = 0; k < 4; k++) din[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_req", 32'({dh, dc, dw}), 32'd0);
    chk("rst_done", 32'(dn), 32'd0);
    chk("rst_dtw", 32'(dtw[0]), 32'd0);
    chk("rst_cw", 32'(cw[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    din[0] = 64'h202015;
    dv[0] = 1'b1;
    b0 = n[0]; d0 = ndone[0]; c0 = ncmd[0];
    pulse(0);
    chk("home_lat", 32'(dh[0]), 32'd1);
    chk("busy_on", 32'(bsy[0]), 32'd1);
    wait_done(0, "t1_done");
    @(negedge clk);
    chk("t1_cnt", 32'(n[0] - b0), 32'd8);
    chk_str("t1", 0, b0, 8, 256'("20 20 15"));
    chk("t1_ncmd", 32'(ncmd[0] - c0), 32'd0);
    chk("t1_ndone", 32'(ndone[0] - d0), 32'd1);
    chk("t1_busy_off", 32'(bsy[0]), 32'd0);
    din[0] = 64'h9AF0C8;
    dv[0] = 1'b0;
    b0 = n[0];
    pulse(0);
    repeat (8) @(negedge clk);
    chk("t2_wait_dw", 32'(dw[0]), 32'd0);
    chk("t2_wait_busy", 32'(bsy[0]), 32'd1);
    chk("t2_wait_home", 32'(dh[0]), 32'd0);
    dv[0] = 1'b1;
    @(negedge clk);
    chk("t2_lat1", 32'(dw[0]), 32'd0);
    @(negedge clk);
    chk("t2_lat2", 32'(dw[0]), 32'd1);
    wait_done(0, "t2_done");
    @(negedge clk);
    chk_str("t2", 0, b0, 8, 256'("9A F0 C8"));
    din[1] = 64'h9AF0C8;
    dv[1] = 1'b1;
    b0 = n[1];
    pulse(1);
    wait_done(1, "t3_done");
    @(negedge clk);
    chk("t3_cnt", 32'(n[1] - b0), 32'd8);
    chk_str("t3", 1, b0, 8, 256'("9a f0 c8"));
    din[2] = 64'h0123456789ABCDEF;
    dv[2] = 1'b1;
    b0 = n[2]; c0 = ncmd[2]; d0 = ndone[2];
    pulse(2);
    wait_done(2, "t4_done");
    @(negedge clk);
    chk("t4_cnt", 32'(n[2] - b0), 32'd23);
    chk("t4_ncmd", 32'(ncmd[2] - c0), 32'd1);
    chk("t4_cmd", 32'(lastcmd[2]), 32'hC0);
    chk("t4_cmd_at", 32'(cmd_at[2] - b0), 32'd16);
    chk("t4_ndone", 32'(ndone[2] - d0), 32'd1);
    chk_str("t4a", 2, b0, 16, 256'("01 23 45 67 89 A"));
    chk_str("t4b", 2, b0 + 16, 7, 256'("B CD EF"));
    din[3] = 64'h0123456789ABCDEF;
    dv[3] = 1'b1;
    b0 = n[3]; c0 = ncmd[3]; d0 = ndone[3];
    pulse(3);
    wait_done(3, "t5_done");
    repeat (4) @(negedge clk);
    chk("t5_cnt", 32'(n[3] - b0), 32'd16);
    chk("t5_ncmd", 32'(ncmd[3] - c0), 32'd0);
    chk("t5_ndone", 32'(ndone[3] - d0), 32'd1);
    chk_str("t5", 3, b0, 16, 256'("01 23 45 67 89 A"));
    din[0] = 64'h202015;
    b0 = n[0]; d0 = ndone[0];
    pulse(0);
    c = 0;
    while (!(dw[0] && n[0] - b0 == 4) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reach", 32'(dw[0]), 32'd1);
    pulse(0);
    c = 0;
    while (!sd[0] && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t6_ack", 32'(sd[0]), 32'd1);
    @(negedge clk);
    chk("t6_gap_home", 32'(dh[0]), 32'd0);
    @(negedge clk);
    chk("t6_home", 32'(dh[0]), 32'd1);
    chk("t6_cnt", 32'(n[0] - b0), 32'd5);
    chk("t6_nodone", 32'(ndone[0] - d0), 32'd0);
    wait_done(0, "t6_done");
    @(negedge clk);
    chk("t6_cnt2", 32'(n[0] - b0), 32'd13);
    chk("t6_ndone", 32'(ndone[0] - d0), 32'd1);
    chk_str("t6", 0, b0 + 5, 8, 256'("20 20 15"));
    ack_en[0] = 1'b0;
    din[0] = 64'h00A5B1;
    pulse(0);
    c = 0;
    while (!dw[0] && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t7_send", 32'(dw[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_req", 32'({dh[0], dc[0], dw[0]}), 32'd0);
    chk("t7_busy", 32'(bsy[0]), 32'd0);
    chk("t7_done", 32'(dn[0]), 32'd0);
    chk("t7_dtw", 32'(dtw[0]), 32'd0);
    b0 = n[0];
    sdm[0] = 1'b1;
    @(negedge clk);
    sdm[0] = 1'b0;
    @(negedge clk);
    chk("t7_late_busy", 32'(bsy[0]), 32'd0);
    chk("t7_late_cnt", 32'(n[0] - b0), 32'd0);
    ack_en[0] = 1'b1;
    pulse(0);
    wait_done(0, "t7_rerun");
    @(negedge clk);
    chk_str("t7", 0, b0, 8, 256'("00 A5 B1"));
    for (int k = 0; k < 4; k++) chk($sformatf("one_req%0d", k), 32'(viol[k]), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
